// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
// Instruction-fetch stage feeding the ID decoder. Keeps a PC, issues in-order
// word fetches on the instruction bus, buffers returned words (with their
// addresses) in a small FIFO and presents the FIFO head at the IF/ID boundary.
// A redirect flushes the FIFO and drops every fetch still in flight.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_jump_en/_addr       redirect request and word-aligned target
//   i_pipe_stop           ID stalled, head is not consumed
//   o_ibus_req/_addr      fetch request and address (address = PC)
//   i_ibus_gnt            request accepted
//   i_ibus_rvalid/_rdata  in-order read response, one per grant
//   o_valid/o_iaddr/o_idata  head instruction (NOP_INST / 0 when empty)
// ---------------------------------------------------------------------------
module if_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_jump_en,
    input  logic [31:0] i_jump_addr,
    input  logic        i_pipe_stop,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_gnt,
    input  logic        i_ibus_rvalid,
    input  logic [31:0] i_ibus_rdata,
    output logic        o_valid,
    output logic [31:0] o_iaddr,
    output logic [31:0] o_idata
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_fifo_addr [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_tag [DEPTH];
    logic [AW-1:0] r_tag_wr;
    logic [AW-1:0] r_tag_rd;

    logic [CW:0]   w_used;
    logic          w_req;
    logic          w_grant;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;

    // Credits: buffered words plus outstanding fetches never exceed DEPTH,
    // so a returning response always finds room in the FIFO.
    assign w_used  = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_req   = i_rst_n & ~i_jump_en & (w_used < LP_DEPTH);
    assign w_grant = w_req & i_ibus_gnt;
    assign w_push  = i_ibus_rvalid & ~i_jump_en & (r_discard == '0);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & ~i_pipe_stop & ~i_jump_en;

    assign o_ibus_req  = w_req;
    assign o_ibus_addr = r_pc;
    assign o_valid     = w_valid;
    assign o_iaddr     = w_valid ? r_fifo_addr[r_rd_ptr] : '0;
    assign o_idata     = w_valid ? r_fifo_data[r_rd_ptr] : NOP_INST;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc       <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
        end else begin
            // Tag queue and in-flight count track the bus regardless of redirects.
            if (w_grant) begin
                r_pc            <= r_pc + 32'd4;
                r_tag[r_tag_wr] <= r_pc;
                r_tag_wr        <= r_tag_wr + AW'(1);
            end
            if (i_ibus_rvalid) begin
                r_tag_rd <= r_tag_rd + AW'(1);
            end
            case ({w_grant, i_ibus_rvalid})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: ;
            endcase

            if (i_jump_en) begin
                r_pc     <= i_jump_addr;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                // Every outstanding fetch (already-discarded ones included)
                // becomes a drop; this cycle's response is dropped here.
                r_discard <= r_inflight - CW'(i_ibus_rvalid);
            end else begin
                if (i_ibus_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_push) begin
                    r_fifo_addr[r_wr_ptr] <= r_tag[r_tag_rd];
                    r_fifo_data[r_wr_ptr] <= i_ibus_rdata;
                    r_wr_ptr              <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch
// Directed self-checking bench for if_prefetch (DEPTH=4). A small in-bench
// bus model grants according to a bench flag and returns each granted word
// exactly one cycle later (when responses are enabled), in order.
// ---------------------------------------------------------------------------
module tb_if_prefetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_jump_en;
    logic [31:0] i_jump_addr;
    logic        i_pipe_stop;
    logic        o_ibus_req;
    logic [31:0] o_ibus_addr;
    logic        i_ibus_gnt;
    logic        i_ibus_rvalid;
    logic [31:0] i_ibus_rdata;
    logic        o_valid;
    logic [31:0] o_iaddr;
    logic [31:0] o_idata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] q_addr[$];   // granted, not yet answered
    logic [31:0] glog[$];     // every granted address since last reset
    logic        rsp_en;
    int unsigned dead_cnt;

    if_prefetch #(
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_jump_en    (i_jump_en),
        .i_jump_addr  (i_jump_addr),
        .i_pipe_stop  (i_pipe_stop),
        .o_ibus_req   (o_ibus_req),
        .o_ibus_addr  (o_ibus_addr),
        .i_ibus_gnt   (i_ibus_gnt),
        .i_ibus_rvalid(i_ibus_rvalid),
        .i_ibus_rdata (i_ibus_rdata),
        .o_valid      (o_valid),
        .o_iaddr      (o_iaddr),
        .o_idata      (o_idata)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // One clock cycle: drive bus response, sample grant, clock, update model.
    task automatic tick();
        logic        g;
        logic        rv;
        logic [31:0] ga;
        i_ibus_rvalid = i_rst_n && rsp_en && (q_addr.size() > 0);
        i_ibus_rdata  = '0;
        if (i_ibus_rvalid)
            i_ibus_rdata = (dead_cnt > 0) ? 32'h0000_DEAD : mkdata(q_addr[0]);
        #1;
        g  = o_ibus_req && i_ibus_gnt;
        ga = o_ibus_addr;
        rv = i_ibus_rvalid;
        @(posedge i_clk);
        #1;
        if (!i_rst_n) begin
            q_addr.delete();
        end else begin
            if (rv) begin
                void'(q_addr.pop_front());
                if (dead_cnt > 0) dead_cnt--;
            end
            if (g) begin
                q_addr.push_back(ga);
                glog.push_back(ga);
            end
        end
    endtask

    task automatic do_reset(input logic stop);
        i_rst_n     = 1'b0;
        i_jump_en   = 1'b0;
        i_jump_addr = '0;
        i_pipe_stop = stop;
        i_ibus_gnt  = 1'b1;
        rsp_en      = 1'b1;
        dead_cnt    = 0;
        tick();
        tick();
        i_rst_n = 1'b1;
        glog.delete();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_jump_en = 1'b0; i_jump_addr = '0; i_pipe_stop = 1'b0;
        i_ibus_gnt = 1'b1; rsp_en = 1'b1; dead_cnt = 0;
        tick();
        tick();
        n_checks++; if (o_ibus_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", o_ibus_req); end
        n_checks++; if (o_ibus_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", o_ibus_addr); end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
        n_checks++; if (o_iaddr !== 32'h0) begin n_fail++; $display("FAIL rst_iaddr: got %h expected 0", o_iaddr); end
        n_checks++; if (o_idata !== NOP) begin n_fail++; $display("FAIL rst_idata: got %h expected %h", o_idata, NOP); end
    endtask

    task automatic test_stream();
        do_reset(1'b0);
        #1;
        n_checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h expected 1/0", o_ibus_req, o_ibus_addr); end
        tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_early: got %b expected 0", o_valid); end
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_iaddr !== 32'h0 || o_idata !== mkdata(32'h0)) begin n_fail++; $display("FAIL stream_head0: got v=%b a=%h d=%h expected 1/0/%h", o_valid, o_iaddr, o_idata, mkdata(32'h0)); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++; if (o_valid !== 1'b1 || o_iaddr !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_head%0d: got v=%b a=%h expected 1/%h", k, o_valid, o_iaddr, 32'(4 * k)); end
        end
        n_checks++; if (glog.size() !== 5) begin n_fail++; $display("FAIL stream_ngrant: got %0d expected 5", glog.size()); end
        for (int i = 0; i < glog.size(); i++) begin
            n_checks++; if (glog[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_gaddr%0d: got %h expected %h", i, glog[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_stop_credits();
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) tick();
        #1;
        n_checks++; if (glog.size() !== 4) begin n_fail++; $display("FAIL stop_ngrant: got %0d expected 4", glog.size()); end
        n_checks++; if (o_ibus_req !== 1'b0) begin n_fail++; $display("FAIL stop_req_off: got %b expected 0", o_ibus_req); end
        n_checks++; if (o_valid !== 1'b1 || o_iaddr !== 32'h0) begin n_fail++; $display("FAIL stop_head0: got v=%b a=%h expected 1/0", o_valid, o_iaddr); end
        i_pipe_stop = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_checks++; if (o_valid !== 1'b1 || o_iaddr !== 32'(4 * k)) begin n_fail++; $display("FAIL stop_drain%0d: got v=%b a=%h expected 1/%h", k, o_valid, o_iaddr, 32'(4 * k)); end
        end
        n_checks++; if (glog.size() < 5 || glog[4] !== 32'h10) begin n_fail++; $display("FAIL stop_resume: got n=%0d expected fifth grant at 00000010", glog.size()); end
    endtask

    task automatic test_gnt_stall();
        do_reset(1'b0);
        tick();
        tick();
        i_ibus_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 32'h8) begin n_fail++; $display("FAIL stall_hold%0d: got req=%b addr=%h expected 1/8", k, o_ibus_req, o_ibus_addr); end
            tick();
        end
        i_ibus_gnt = 1'b1;
        tick();
        tick();
        n_checks++; if (glog.size() !== 4) begin n_fail++; $display("FAIL stall_ngrant: got %0d expected 4", glog.size()); end
        for (int i = 0; i < glog.size(); i++) begin
            n_checks++; if (glog[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stall_gaddr%0d: got %h expected %h", i, glog[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_jump();
        logic        seen_dead;
        logic [31:0] first_a;
        logic [31:0] first_d;
        do_reset(1'b0);
        tick();
        i_pipe_stop = 1'b1;
        tick();
        rsp_en = 1'b0;
        tick();
        i_jump_en = 1'b1; i_jump_addr = 32'h100;
        #1;
        n_checks++; if (o_ibus_req !== 1'b0) begin n_fail++; $display("FAIL jump_req_cycle: got %b expected 0", o_ibus_req); end
        tick();
        i_jump_en = 1'b0;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL jump_flush: got %b expected 0", o_valid); end
        #1;
        n_checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 32'h100) begin n_fail++; $display("FAIL jump_target_req: got req=%b addr=%h expected 1/100", o_ibus_req, o_ibus_addr); end
        i_pipe_stop = 1'b0; rsp_en = 1'b1; dead_cnt = 2;
        seen_dead = 1'b0; first_a = '1; first_d = '1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_valid === 1'b1 && o_idata === 32'h0000_DEAD) seen_dead = 1'b1;
            if (o_valid === 1'b1 && first_a === 32'hFFFF_FFFF) begin first_a = o_iaddr; first_d = o_idata; end
        end
        n_checks++; if (seen_dead !== 1'b0) begin n_fail++; $display("FAIL jump_late_dropped: got dead_seen=%b expected 0", seen_dead); end
        n_checks++; if (first_a !== 32'h100 || first_d !== mkdata(32'h100)) begin n_fail++; $display("FAIL jump_first_head: got a=%h d=%h expected 100/%h", first_a, first_d, mkdata(32'h100)); end
    endtask

    task automatic test_back_to_back_jump();
        do_reset(1'b0);
        tick();
        tick();
        tick();
        // Response in flight and a poppable head coincide with the first jump.
        i_jump_en = 1'b1; i_jump_addr = 32'h100;
        tick();
        i_jump_addr = 32'h200;
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_flush: got %b expected 0", o_valid); end
        tick();
        i_jump_en = 1'b0;
        #1;
        n_checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_target: got req=%b addr=%h expected 1/200", o_ibus_req, o_ibus_addr); end
        tick();
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_iaddr !== 32'h200 || o_idata !== mkdata(32'h200)) begin n_fail++; $display("FAIL b2b_head: got v=%b a=%h d=%h expected 1/200/%h", o_valid, o_iaddr, o_idata, mkdata(32'h200)); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1);
        tick();
        tick();
        tick();
        rsp_en = 1'b0;
        tick();
        n_checks++; if (o_valid !== 1'b1 || q_addr.size() !== 2) begin n_fail++; $display("FAIL rmid_setup: got v=%b inflight=%0d expected 1/2", o_valid, q_addr.size()); end
        i_rst_n = 1'b0;
        tick();
        n_checks++; if (o_ibus_req !== 1'b0 || o_ibus_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_bus: got req=%b addr=%h expected 0/0", o_ibus_req, o_ibus_addr); end
        n_checks++; if (o_valid !== 1'b0 || o_iaddr !== 32'h0 || o_idata !== NOP) begin n_fail++; $display("FAIL rmid_head: got v=%b a=%h d=%h expected 0/0/%h", o_valid, o_iaddr, o_idata, NOP); end
        i_rst_n = 1'b1; rsp_en = 1'b1; i_pipe_stop = 1'b0;
        glog.delete();
        #1;
        n_checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_restart: got req=%b addr=%h expected 1/0", o_ibus_req, o_ibus_addr); end
        tick();
        tick();
        n_checks++; if (o_valid !== 1'b1 || o_iaddr !== 32'h0 || o_idata !== mkdata(32'h0)) begin n_fail++; $display("FAIL rmid_head0: got v=%b a=%h d=%h expected 1/0/%h", o_valid, o_iaddr, o_idata, mkdata(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stop_credits();
        test_gnt_stall();
        test_jump();
        test_back_to_back_jump();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
